bumper_conditioner: RTL

- Input-conditioning stage between the six raw bumper switches and the motion controller.
- Per bumper: two-flop synchronisation, counter-based debounce, press/release event pulses, and a sticky hit mask that the controller clears.
- Its outputs replace the raw bumper bus at the controller input.
- Raw bumpers are active-low (pressed = 0). All outputs are active-high.

---
 rtl/bumper_pkg.sv | 8 +
 rtl/bumper_debounce_bit.sv | 58 +++++
 rtl/bumper_conditioner.sv | 48 ++++
 3 files changed

// File: rtl/bumper_pkg.sv
// Shared constants for the bumper input-conditioning stage.
package bumper_pkg;

  localparam int N_BMP             = 6;
  localparam int DB_CYCLES_DEFAULT = 120000;
  localparam int CNT_W_DEFAULT     = $clog2(DB_CYCLES_DEFAULT);

endpackage

// File: rtl/bumper_debounce_bit.sv
// Single bumper: two-flop synchroniser, counter debounce and edge events.
module bumper_debounce_bit
  import bumper_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic pressed,
  output logic press_evt,
  output logic release_evt,
  output logic press_nxt
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("bumper_debounce_bit: DB_CYCLES must be at least 2");
  end

  logic             s1;
  logic             s2;
  logic             stable_n;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // A level change is accepted on the sample that completes a full run of disagreement.
  assign accept    = (s2 != stable_n) && (cnt == CNT_MAX);
  assign press_nxt = accept & ~s2;
  assign pressed   = ~stable_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      stable_n    <= 1'b1;
      cnt         <= '0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      s1          <= raw_n;
      s2          <= s1;
      press_evt   <= accept & ~s2;
      release_evt <= accept & s2;
      if (s2 == stable_n) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable_n <= s2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bumper_conditioner.sv
// Conditions the raw active-low bumper bus into debounced levels, events and a sticky hit mask.
module bumper_conditioner
  import bumper_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BMP-1:0] bmp_n,
  input  logic [N_BMP-1:0] hit_clr,
  output logic [N_BMP-1:0] pressed,
  output logic [N_BMP-1:0] press_evt,
  output logic [N_BMP-1:0] release_evt,
  output logic [N_BMP-1:0] hit_mask,
  output logic             hit,
  output logic             any_pressed
);

  logic [N_BMP-1:0] press_nxt;

  for (genvar i = 0; i < N_BMP; i++) begin : g_bit
    bumper_debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk        (clk),
      .rst        (rst),
      .raw_n      (bmp_n[i]),
      .pressed    (pressed[i]),
      .press_evt  (press_evt[i]),
      .release_evt(release_evt[i]),
      .press_nxt  (press_nxt[i])
    );
  end

  // A new press wins over a simultaneous clear of the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_mask    <= '0;
      hit         <= 1'b0;
      any_pressed <= 1'b0;
    end else begin
      hit_mask    <= (hit_mask & ~hit_clr) | press_nxt;
      hit         <= |hit_mask;
      any_pressed <= |pressed;
    end
  end

endmodule
